// File: rtl/gate_sweep_checker.sv
// Stimulus/response checker for the two-input gate unit (y1=NAND, y2=OR, y3=XOR).
// Sweeps {a,b} through 00..11 for PASSES runs, holding each vector SETTLE_CYCLES before one CHECK cycle.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y1,
  input  logic       y2,
  input  logic       y3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_vec,
  output logic [2:0] fail_bits
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SWEEP_LAST  = 8'(PASSES - 1);

  state_t     state, state_nxt;
  logic       start_q;
  logic [1:0] idx;
  logic [7:0] sweep;
  logic [3:0] settle_cnt;
  logic [2:0] exp_y, diff;
  logic       mismatch, idle_or_done;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign exp_y        = {~(a & b), a | b, a ^ b};
  assign diff         = {y1, y2, y3} ^ exp_y;
  assign mismatch     = |diff;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_q) state_nxt = SETTLE;
      SETTLE:     if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
      CHECK:      state_nxt = (idx == 2'd3 && sweep == SWEEP_LAST) ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == CHECK);
    done = (state == DONE);
    pass = (state == DONE) && (err_count == 8'd0);
  end

  // start is registered (and only accepted when not busy), so a run begins one
  // edge after the start sample; a start seen in the final CHECK cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b0;
      idx        <= 2'd0;
      {a, b}     <= 2'b00;
      sweep      <= 8'd0;
      settle_cnt <= 4'd0;
      err_count  <= 8'd0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
      fail_bits  <= 3'd0;
    end else begin
      start_q <= start & idle_or_done;
      case (state)
        IDLE, DONE: if (start_q) begin
          idx        <= 2'd0;
          {a, b}     <= 2'b00;
          sweep      <= 8'd0;
          settle_cnt <= 4'd0;
          err_count  <= 8'd0;
          fail_valid <= 1'b0;
          fail_vec   <= 2'd0;
          fail_bits  <= 3'd0;
        end
        SETTLE: settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
        CHECK: begin
          if (mismatch) begin
            if (err_count != 8'hff) err_count <= err_count + 8'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= {a, b};
              fail_bits  <= diff;
            end
          end
          if (idx != 2'd3) begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
          end else if (sweep != SWEEP_LAST) begin
            idx    <= 2'd0;
            {a, b} <= 2'b00;
            sweep  <= sweep + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: several checker instances against a behavioural gate model with injectable faults.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // fault modes: 0 ideal, 1 y2 stuck 0, 2 y3 inverted, 3 y1 inverted, 4 ideal through 2-cycle delay
  function automatic logic [2:0] gate(input logic ia, input logic ib, input int mode);
    logic [2:0] y;
    y = {~(ia & ib), ia | ib, ia ^ ib};
    case (mode)
      1: y[1] = 1'b0;
      2: y[0] = ~y[0];
      3: y[2] = ~y[2];
      default: ;
    endcase
    return y;
  endfunction

  // u0: defaults, selectable mode
  logic s0 = 1'b0; int m0 = 0;
  logic a0, b0, y10, y20, y30, busy0, done0, pass0, fv0;
  logic [7:0] err0; logic [1:0] fvec0; logic [2:0] fbits0;
  logic [1:0] p0a = 2'b00, p0b = 2'b00;
  always @(posedge clk) begin p0a <= {a0, b0}; p0b <= p0a; end
  assign {y10, y20, y30} = (m0 == 4) ? gate(p0b[1], p0b[0], 0) : gate(a0, b0, m0);
  gate_sweep_checker u0 (.clk(clk), .reset(reset), .start(s0), .a(a0), .b(b0),
    .y1(y10), .y2(y20), .y3(y30), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0), .fail_bits(fbits0));

  // u3: PASSES=3, y3 inverted
  logic s3 = 1'b0;
  logic a3, b3, y13, y23, y33, busy3, done3, pass3, fv3;
  logic [7:0] err3; logic [1:0] fvec3; logic [2:0] fbits3;
  assign {y13, y23, y33} = gate(a3, b3, 2);
  gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(3)) u3 (.clk(clk), .reset(reset), .start(s3),
    .a(a3), .b(b3), .y1(y13), .y2(y23), .y3(y33), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_valid(fv3), .fail_vec(fvec3), .fail_bits(fbits3));

  // uh: PASSES=100, y1 inverted
  logic sh = 1'b0;
  logic ah, bh, y1h, y2h, y3h, busyh, doneh, passh, fvh;
  logic [7:0] errh; logic [1:0] fvech; logic [2:0] fbitsh;
  assign {y1h, y2h, y3h} = gate(ah, bh, 3);
  gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(100)) uh (.clk(clk), .reset(reset), .start(sh),
    .a(ah), .b(bh), .y1(y1h), .y2(y2h), .y3(y3h), .busy(busyh), .done(doneh), .pass(passh),
    .err_count(errh), .fail_valid(fvh), .fail_vec(fvech), .fail_bits(fbitsh));

  // us: SETTLE_CYCLES=3, ideal gate behind a 2-cycle delay
  logic ss = 1'b0;
  logic as_, bs, y1s, y2s, y3s, busys, dones, passs, fvs;
  logic [7:0] errs; logic [1:0] fvecs; logic [2:0] fbitss;
  logic [1:0] psa = 2'b00, psb = 2'b00;
  always @(posedge clk) begin psa <= {as_, bs}; psb <= psa; end
  assign {y1s, y2s, y3s} = gate(psb[1], psb[0], 0);
  gate_sweep_checker #(.SETTLE_CYCLES(3), .PASSES(1)) us (.clk(clk), .reset(reset), .start(ss),
    .a(as_), .b(bs), .y1(y1s), .y2(y2s), .y3(y3s), .busy(busys), .done(dones), .pass(passs),
    .err_count(errs), .fail_valid(fvs), .fail_vec(fvecs), .fail_bits(fbitss));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0: return done0;
      3: return done3;
      1: return doneh;
      default: return dones;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: s0 = v;
      3: s3 = v;
      1: sh = v;
      default: ss = v;
    endcase
  endtask

  // Pulse start (sampled at edge k) and return the edge offset from k at which done rises; -1 on timeout.
  task automatic run(input int w, input int budget, output int lat);
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done_of(w)) begin lat = i; break; end
    end
  endtask

  int lat;

  initial begin
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_ab",    {30'd0, a0, b0}, 0);
    check("rst_busy",  busy0, 0);
    check("rst_done",  done0, 0);
    check("rst_pass",  pass0, 0);
    check("rst_err",   err0, 0);
    check("rst_fv",    fv0, 0);
    check("rst_fvec",  fvec0, 0);
    check("rst_fbits", fbits0, 0);

    // ideal run, cycle by cycle
    m0 = 0;
    s0 = 1'b1; tick(); s0 = 1'b0;               // edge k
    check("k_busy", busy0, 0);
    tick();                                      // k+1
    check("k1_busy", busy0, 1);
    check("k1_ab", {a0, b0}, 2'b00);
    tick(); check("k2_ab", {a0, b0}, 2'b00);
    tick(); check("k3_ab", {a0, b0}, 2'b01);
    tick(); check("k4_ab", {a0, b0}, 2'b01);
    tick(); check("k5_ab", {a0, b0}, 2'b10);
    tick(); tick(); check("k7_ab", {a0, b0}, 2'b11);
    tick();                                      // k+8
    check("k8_busy", busy0, 1);
    check("k8_done", done0, 0);
    tick();                                      // k+9
    check("k9_done", done0, 1);
    check("k9_busy", busy0, 0);
    check("ideal_pass", pass0, 1);
    check("ideal_err", err0, 0);
    check("ideal_fv", fv0, 0);
    check("ideal_ab_hold", {a0, b0}, 2'b11);

    // y2 stuck at 0
    m0 = 1;
    run(0, 50, lat);
    check("y2s_lat", lat, 9);
    check("y2s_err", err0, 3);
    check("y2s_fv", fv0, 1);
    check("y2s_fvec", fvec0, 2'b01);
    check("y2s_fbits", fbits0, 3'b010);
    check("y2s_pass", pass0, 0);

    // restart from DONE after errors; re-pulsed start during SETTLE is ignored
    m0 = 0;
    s0 = 1'b1; tick(); s0 = 1'b0;               // edge k
    tick();                                      // k+1
    check("rs_err_clr", err0, 0);
    check("rs_fv_clr", fv0, 0);
    check("rs_busy", busy0, 1);
    s0 = 1'b1; tick(); s0 = 1'b0;               // k+2, sampled while busy
    lat = -1;
    for (int i = 3; i <= 40; i++) begin
      tick();
      if (done0) begin lat = i; break; end
    end
    check("rs_lat", lat, 9);
    check("rs_pass", pass0, 1);
    check("rs_err", err0, 0);
    tick(); tick();
    check("rs_no_restart", busy0, 0);

    // reset mid-run at index 2
    m0 = 1;
    s0 = 1'b1; tick(); s0 = 1'b0;               // edge k
    for (int i = 0; i < 5; i++) tick();          // k+5
    check("mr_idx2", {a0, b0}, 2'b10);
    check("mr_busy", busy0, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mr_ab", {a0, b0}, 0);
    check("mr_busy0", busy0, 0);
    check("mr_done", done0, 0);
    check("mr_err", err0, 0);
    check("mr_fv", fv0, 0);
    tick();
    check("mr_idle", busy0 | done0, 0);

    // PASSES=3, y3 inverted
    run(3, 60, lat);
    check("p3_lat", lat, 25);
    check("p3_err", err3, 12);
    check("p3_fvec", fvec3, 2'b00);
    check("p3_fbits", fbits3, 3'b001);
    check("p3_pass", pass3, 0);

    // PASSES=100, y1 inverted: saturation
    run(1, 1000, lat);
    check("p100_lat", lat, 801);
    check("p100_err", errh, 255);
    check("p100_fbits", fbitsh, 3'b100);
    tick(); tick(); tick();
    check("p100_hold", errh, 255);

    // delayed gate: enough settle vs too little
    run(2, 60, lat);
    check("s3_lat", lat, 17);
    check("s3_err", errs, 0);
    check("s3_pass", passs, 1);
    m0 = 4;
    run(0, 50, lat);
    check("s1_dly_lat", lat, 9);
    check("s1_dly_err_nz", err0 != 8'd0, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
